// File: rtl/amo_reg_sequencer_if.sv
// Port bundle between the atomic read-modify-write sequencer and its environment:
// the request/completion handshake from decode plus the register-file port set.
// master = environment (decode stage + register file), slave = the sequencer.
interface amo_reg_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // request side
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_rs1;
  logic [ADDR_WIDTH-1:0] req_rs2;
  logic [ADDR_WIDTH-1:0] req_rd;
  // register file side
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] read_data3;
  // status / completion
  logic                  busy;
  logic                  done_valid;
  logic [DATA_WIDTH-1:0] done_result;
  logic                  done_err;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd,
    output read_data1, read_data2, read_data3,
    input  req_ready, read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  busy, done_valid, done_result, done_err
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd,
    input  read_data1, read_data2, read_data3,
    output req_ready, read_reg1, read_reg2, write_reg, write_data, reg_write,
    output busy, done_valid, done_result, done_err
  );
endinterface

// File: rtl/amo_reg_sequencer.sv
// Atomic read-modify-write sequencer on the register-file port set.
// One request runs IDLE->READ->EXEC->WRITE->DONE; operands are sampled in READ,
// the new value is committed by a single-cycle reg_write in WRITE, and the old
// value of rd is reported with a one-cycle done_valid pulse in DONE.
module amo_reg_sequencer #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  amo_reg_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q;
  logic [3:0]            op_q;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] cmp_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] new_q;
  logic                  err_q;
  logic                  reg_write_q;
  logic                  done_valid_q;
  logic [DATA_WIDTH-1:0] done_result_q;
  logic                  done_err_q;

  logic [DATA_WIDTH-1:0] new_d;
  logic                  we_d;
  logic                  err_d;
  logic                  rd_is_zero_d;
  logic                  we_final_d;

  // Operation decode: new value, write enable and illegal-op flag from sampled operands.
  always_comb begin
    new_d = src_q;
    we_d  = 1'b1;
    err_d = 1'b0;
    case (op_q)
      4'd0:    new_d = src_q;
      4'd1:    new_d = old_q + src_q;
      4'd2:    new_d = old_q & src_q;
      4'd3:    new_d = old_q | src_q;
      4'd4:    new_d = old_q ^ src_q;
      4'd5:    new_d = ($signed(old_q) < $signed(src_q)) ? old_q : src_q;
      4'd6:    new_d = ($signed(old_q) > $signed(src_q)) ? old_q : src_q;
      4'd7:    new_d = (old_q < src_q) ? old_q : src_q;
      4'd8:    new_d = (old_q > src_q) ? old_q : src_q;
      4'd9: begin
        new_d = src_q;
        we_d  = (old_q == cmp_q);
      end
      default: begin
        new_d = old_q;
        we_d  = 1'b0;
        err_d = 1'b1;
      end
    endcase
  end

  // Writes to r0 are dropped when r0 is hardwired; the result is still reported.
  assign rd_is_zero_d = ZERO_REG_HARDWIRED && (rd_q == {ADDR_WIDTH{1'b0}});
  assign we_final_d   = we_d && !rd_is_zero_d;

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 4'd0;
      rs1_q         <= {ADDR_WIDTH{1'b0}};
      rs2_q         <= {ADDR_WIDTH{1'b0}};
      rd_q          <= {ADDR_WIDTH{1'b0}};
      cmp_q         <= {DATA_WIDTH{1'b0}};
      src_q         <= {DATA_WIDTH{1'b0}};
      old_q         <= {DATA_WIDTH{1'b0}};
      new_q         <= {DATA_WIDTH{1'b0}};
      err_q         <= 1'b0;
      reg_write_q   <= 1'b0;
      done_valid_q  <= 1'b0;
      done_result_q <= {DATA_WIDTH{1'b0}};
      done_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            rs1_q   <= bus.req_rs1;
            rs2_q   <= bus.req_rs2;
            rd_q    <= bus.req_rd;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          cmp_q   <= bus.read_data1;
          src_q   <= bus.read_data2;
          old_q   <= bus.read_data3;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          new_q       <= new_d;
          err_q       <= err_d;
          reg_write_q <= we_final_d;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          reg_write_q   <= 1'b0;
          done_valid_q  <= 1'b1;
          done_result_q <= old_q;
          done_err_q    <= err_q;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          done_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          reg_write_q  <= 1'b0;
          done_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) && !reset;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.read_reg1   = rs1_q;
  assign bus.read_reg2   = rs2_q;
  assign bus.write_reg   = rd_q;
  assign bus.write_data  = new_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_result = done_result_q;
  assign bus.done_err    = done_err_q;

endmodule
